// File: rtl/memory_responder.sv
// memory_responder: single-port word memory answering level-held read/write
// requests with a programmable busy latency.
//
// Ports:
//   CLK      - sole clock, all state changes on the rising edge
//   RST      - synchronous active-high reset (memory contents are kept)
//   ramaddr  - byte address; word index = ramaddr[log2(DEPTH)+1:2]
//   ramstore - write data
//   ramREN   - read request, held until ACCESS is seen
//   ramWEN   - write request, held until ACCESS is seen
//   ramload  - registered read data, holds until the next read completes
//   ramstate - registered status: FREE, BUSY, ACCESS, ERROR
//
// Parameters: LAT (1..15) busy cycles before ACCESS, DEPTH words of storage.
// Optional build macro MEM_ALIGN_CHECK_EN: requests with ramaddr[1:0] != 0
// fault instead of being served on the word index.

package cpu_types_pkg;
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;
endpackage

module memory_responder
  import cpu_types_pkg::*;
#(
  parameter int unsigned LAT   = 2,
  parameter int unsigned DEPTH = 256
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] ramaddr,
  input  logic [31:0] ramstore,
  input  logic        ramREN,
  input  logic        ramWEN,
  output logic [31:0] ramload,
  output ramstate_t   ramstate
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [29:0] DEPTH_W  = 30'(DEPTH);
  localparam logic [3:0]  CNT_INIT = 4'(LAT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DONE  = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic [31:0] r_addr;
  logic [31:0] r_data;
  logic        r_wen;
  logic [31:0] r_ramload;
  ramstate_t   r_ramstate;
  ramstate_t   w_next_ramstate;

  logic [31:0] r_mem [DEPTH];

  logic          w_one_req;
  logic          w_both_req;
  logic          w_any_req;
  logic          w_bad_addr;
  logic          w_changed;
  logic          w_latch;
  logic          w_dec;
  logic          w_rd;
  logic          w_wr;
  logic [AW-1:0] w_idx;

  assign w_one_req  = ramREN ^ ramWEN;
  assign w_both_req = ramREN & ramWEN;
  assign w_any_req  = ramREN | ramWEN;
  assign w_changed  = (ramaddr != r_addr) || (ramWEN != r_wen);
  assign w_idx      = r_addr[AW+1:2];

`ifdef MEM_ALIGN_CHECK_EN
  assign w_bad_addr = (ramaddr[31:2] >= DEPTH_W) || (ramaddr[1:0] != 2'b00);
`else
  assign w_bad_addr = (ramaddr[31:2] >= DEPTH_W);
`endif

  always_comb begin
    w_next          = r_state;
    w_latch         = 1'b0;
    w_dec           = 1'b0;
    w_rd            = 1'b0;
    w_wr            = 1'b0;
    w_next_ramstate = FREE;
    case (r_state)
      // DONE accepts a new request exactly like IDLE does.
      IDLE, DONE: begin
        if (w_both_req || (w_one_req && w_bad_addr)) begin
          w_next = FAULT;
        end else if (w_one_req) begin
          w_next  = WAIT;
          w_latch = 1'b1;
        end else begin
          w_next = IDLE;
        end
      end
      WAIT: begin
        if (w_both_req) begin
          w_next = FAULT;
        end else if (!w_any_req) begin
          w_next = IDLE;
        end else if (w_changed) begin
          // A changed request restarts the whole latency window.
          if (w_bad_addr) begin
            w_next = FAULT;
          end else begin
            w_next  = WAIT;
            w_latch = 1'b1;
          end
        end else if (r_cnt == '0) begin
          w_next = DONE;
          w_rd   = ~r_wen;
          w_wr   = r_wen;
        end else begin
          w_dec = 1'b1;
        end
      end
      FAULT:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
    case (w_next)
      WAIT:    w_next_ramstate = BUSY;
      DONE:    w_next_ramstate = ACCESS;
      FAULT:   w_next_ramstate = ERROR;
      default: w_next_ramstate = FREE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_data     <= '0;
      r_wen      <= 1'b0;
      r_ramload  <= '0;
      r_ramstate <= FREE;
    end else begin
      r_state    <= w_next;
      r_ramstate <= w_next_ramstate;
      if (w_latch) begin
        r_addr <= ramaddr;
        r_data <= ramstore;
        r_wen  <= ramWEN;
        r_cnt  <= CNT_INIT;
      end else if (w_dec) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_rd) begin
        r_ramload <= r_mem[w_idx];
      end
    end
  end

  // Storage is never reset; the write is suppressed on reset edges so a
  // transaction interrupted by RST leaves memory untouched.
  always_ff @(posedge CLK) begin
    if (w_wr && !RST) begin
      r_mem[w_idx] <= r_data;
    end
  end

  assign ramload  = r_ramload;
  assign ramstate = r_ramstate;

endmodule

// File: tb/tb_memory_responder.sv
// tb_memory_responder: randomized scoreboard bench for memory_responder.
// The driver expresses each transaction in terms of the protocol rules
// (LAT busy cycles, one ACCESS cycle, ERROR for illegal requests) against a
// word-array memory model, pushing the expected status/data for every cycle;
// an independent monitor pops and compares on each falling edge.

module tb_memory_responder;
  import cpu_types_pkg::*;

  localparam int unsigned LAT   = 2;
  localparam int unsigned DEPTH = 256;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] ramaddr = '0;
  logic [31:0] ramstore = '0;
  logic        ramREN = 1'b0;
  logic        ramWEN = 1'b0;
  logic [31:0] ramload;
  ramstate_t   ramstate;

  memory_responder #(.LAT(LAT), .DEPTH(DEPTH)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramload  (ramload),
    .ramstate (ramstate)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    ramstate_t   st;
    logic [31:0] ld;
    int          tag;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_load = '0;
  int          tag = 0;

  // Monitor: one expected entry per clock cycle after each driven edge.
  always @(negedge CLK) begin
    if (q.size() != 0) begin
      mon_e = q.pop_front();
      checks++;
      if (ramstate !== mon_e.st) begin
        errors++;
        $display("FAIL ramstate tag=%0d got=%0d want=%0d", mon_e.tag, ramstate, mon_e.st);
      end
      checks++;
      if (ramload !== mon_e.ld) begin
        errors++;
        $display("FAIL ramload tag=%0d got=%h want=%h", mon_e.tag, ramload, mon_e.ld);
      end
    end
  end

  function automatic bit addr_ok(input logic [31:0] a);
    bit ok;
    ok = (a[31:2] < 30'(DEPTH));
`ifdef MEM_ALIGN_CHECK_EN
    if (a[1:0] != 2'b00) ok = 1'b0;
`endif
    return ok;
  endfunction

  task automatic step(input logic rst, input logic ren, input logic wen,
                      input logic [31:0] a, input logic [31:0] d, input ramstate_t st);
    RST = rst; ramREN = ren; ramWEN = wen; ramaddr = a; ramstore = d;
    @(posedge CLK);
    q.push_back('{st: st, ld: m_load, tag: tag});
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, $urandom, $urandom, FREE);
  endtask

  // Full transaction; hold_next leaves the request to the next call so the
  // following transaction starts at the ACCESS exit edge.
  task automatic access(input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input bit hold_next);
    int unsigned idx;
    if (!addr_ok(a)) begin
      step(1'b0, !wr, wr, a, d, ERROR);
      idle();
      return;
    end
    idx = int'(a[31:2]);
    for (int i = 0; i < int'(LAT); i++) step(1'b0, !wr, wr, a, d, BUSY);
    if (wr) m_mem[idx] = d;
    else    m_load = m_mem[idx];
    step(1'b0, !wr, wr, a, d, ACCESS);
    if (!hold_next) idle();
  endtask

  // Start a valid request, keep it j edges, then disturb it:
  // kind 0 drop, 1 reset, 2 both enables, 3 leave for a changed request.
  task automatic partial(input bit wr, input logic [31:0] a, input logic [31:0] d,
                         input int j, input int kind);
    for (int i = 0; i < j; i++) step(1'b0, !wr, wr, a, d, BUSY);
    case (kind)
      0: idle();
      1: begin
        m_load = '0;
        step(1'b1, !wr, wr, a, d, FREE);
        idle();
      end
      2: begin
        step(1'b0, 1'b1, 1'b1, a, d, ERROR);
        idle();
      end
      default: ;
    endcase
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    if ($urandom_range(0, 7) == 0) a = ((DEPTH + $urandom_range(0, 15)) << 2) | $urandom_range(0, 3);
    else a = ($urandom_range(0, 15) << 2) | (($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : 0);
    return a;
  endfunction

  function automatic logic [31:0] rand_valid_addr();
    return 32'($urandom_range(0, 15) << 2);
  endfunction

  initial begin
    logic [31:0] a, b, d;
    bit          wr, wr2;
    int          j, kind;

    tag = 1;
    step(1'b1, 1'b1, 1'b0, 32'h10, 32'h1, FREE);
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, FREE);

    tag = 2;
    for (int w = 0; w < 16; w++) access(1'b1, 32'(w << 2), $urandom, 1'b0);

    tag = 30;
    access(1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
    access(1'b0, 32'h10, 32'h0, 1'b0);

    tag = 31;
    partial(1'b0, 32'h20, 32'h0, 1, 3);
    access(1'b0, 32'h24, 32'h0, 1'b0);
    access(1'b0, 32'h20, 32'h0, 1'b0);

    tag = 32;
    step(1'b0, 1'b1, 1'b1, 32'h8, 32'hCAFEF00D, ERROR);
    idle();
    access(1'b0, 32'h8, 32'h0, 1'b0);

    tag = 33;
    partial(1'b1, 32'h30, 32'h12345678, 1, 1);
    access(1'b0, 32'h30, 32'h0, 1'b0);

    tag = 34;
    access(1'b0, 32'h402, 32'h0, 1'b0);
    access(1'b0, 32'h2, 32'h0, 1'b0);

    tag = 35;
    access(1'b0, 32'h10, 32'h0, 1'b1);
    access(1'b0, 32'h4, 32'h0, 1'b0);

    tag = 36;
    access(1'b0, 32'h14, 32'h0, 1'b1);
    access(1'b0, 32'h14, 32'h0, 1'b0);
    access(1'b1, 32'h18, 32'h55AA55AA, 1'b1);
    access(1'b0, 32'h18, 32'h0, 1'b0);
    partial(1'b1, 32'h1C, 32'h77777777, int'(LAT), 0);
    access(1'b0, 32'h1C, 32'h0, 1'b0);
    partial(1'b0, 32'h0, 32'h0, int'(LAT), 2);

    tag = 100;
    for (int n = 0; n < 300; n++) begin
      wr = $urandom_range(0, 1);
      d  = $urandom;
      case ($urandom_range(0, 5))
        0, 1: access(wr, rand_addr(), d, $urandom_range(0, 1));
        2: begin
          a = rand_valid_addr();
          j = $urandom_range(1, int'(LAT));
          kind = $urandom_range(0, 2);
          partial(wr, a, d, j, kind);
        end
        3: begin
          a   = rand_valid_addr();
          b   = rand_addr();
          wr2 = $urandom_range(0, 1);
          if (b == a && wr2 == wr) b = a ^ 32'h4;
          partial(wr, a, d, $urandom_range(1, int'(LAT)), 3);
          access(wr2, b, $urandom, 1'b0);
        end
        4: begin
          step(1'b0, 1'b1, 1'b1, rand_addr(), d, ERROR);
          idle();
        end
        default: idle();
      endcase
    end

    idle();
    @(negedge CLK);
    @(negedge CLK);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d want=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/memory_responder.md
MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 Parameter LAT, default 2: BUSY cycles before ACCESS; legal range 1..15.
REQ-002 Parameter DEPTH, default 256: number of 32-bit storage words.
REQ-003 CLK  input  1  sole clock; all state changes on rising edge.
REQ-004 RST  input  1  reset, synchronous and active-high.
REQ-005 ramaddr  input  32  byte address; word index = ramaddr[log2(DEPTH)+1:2].
REQ-006 ramstore  input  32  write data.
REQ-007 ramREN  input  1  read request, level-held by the requester until ACCESS is seen.
REQ-008 ramWEN  input  1  write request, level-held by the requester until ACCESS is seen.
REQ-009 ramload  output  32  read data, registered.
REQ-010 ramstate  output  2  ramstate_t from cpu_types_pkg: FREE, BUSY, ACCESS, ERROR; registered.

Function
REQ-011 FSM states: IDLE (ramstate FREE), WAIT (BUSY), DONE (ACCESS), FAULT (ERROR).
REQ-012 Request: exactly one of ramREN/ramWEN high at an edge; the edge latches addr, data and op and loads counter = LAT-1.
REQ-013 Request sampled at edge k in IDLE: BUSY for cycles k+1..k+LAT; ACCESS for exactly one cycle, after edge k+LAT.
REQ-014 WAIT: counter decrements each edge while the request is unchanged; the edge at which counter==0 enters DONE.
REQ-015 Read: the edge entering DONE registers mem[index] onto ramload; the value holds until the next read completes.
REQ-016 Write: the edge entering DONE writes the latched ramstore to mem[index]; ramload is unchanged.
REQ-017 WAIT, address or op at an edge differs from latched: abort, relatch, reload counter with LAT-1, stay BUSY; no memory write.
REQ-018 WAIT, request dropped at an edge: return to IDLE (FREE); no write; ramload unchanged.
REQ-019 DONE lasts one cycle; a request sampled at its exit edge starts a new transaction (WAIT, BUSY); otherwise IDLE.
REQ-020 ramREN and ramWEN both high at any sampled edge: enter FAULT; ramstate ERROR for one cycle, then IDLE; no write.
REQ-021 Index >= DEPTH (ramaddr bits above the index field nonzero): FAULT, as in REQ-020.
REQ-022 Back-to-back reads to the same address each take the full LAT+1 cycles; there is no caching.
REQ-023 Memory write and read of the same word never occur in one cycle; a read following a write returns the new data.

Reset
REQ-024 RST high at an edge: FSM to IDLE, counter 0, ramstate FREE, ramload 0, latched request cleared.
REQ-025 RST mid-transaction: the transaction is discarded; a pending write is not performed.
REQ-026 Memory contents are not cleared by RST.
REQ-027 Requests are ignored on any edge where RST is high.

Configuration
REQ-028 Macro MEM_ALIGN_CHECK_EN defined: a request with ramaddr[1:0] != 0 enters FAULT (ERROR one cycle, no write).
REQ-029 MEM_ALIGN_CHECK_EN undefined: ramaddr[1:0] is ignored and the access proceeds on the word index.

Verification
REQ-030 LAT=2, after reset: ramWEN with addr 0x10 and data 0xDEADBEEF -> BUSY 2 cycles, ACCESS 1 cycle; then ramREN at 0x10 -> ramload 0xDEADBEEF during ACCESS.
REQ-031 LAT=2, ramREN at 0x20, addr changed to 0x24 after 1 BUSY cycle -> BUSY continues 2 more cycles; ACCESS returns mem[0x24]; mem[0x20] untouched.
REQ-032 ramREN and ramWEN both high with addr 0x8 -> ERROR for one cycle, then FREE; mem[0x8] unchanged.
REQ-033 ramWEN with data 0x12345678 at 0x30, RST asserted in the 1st BUSY cycle -> FREE, ramload 0; a later read of 0x30 returns the old value.
REQ-034 addr 0x402 read with DEPTH=256: with MEM_ALIGN_CHECK_EN -> ERROR (misaligned); without it -> ERROR (index out of range); addr 0x2 without the macro -> returns mem[0].
REQ-035 Request held high across ACCESS with a new address 0x4 -> ACCESS, then immediately BUSY for 2 cycles, then ACCESS with mem[0x4].
